// File: rtl/fast_serial_device.sv
// Fast-serial (FSDI/FSDO/FSCLK) device endpoint: RX frames into a FWFT FIFO,
// TX bytes out to the host, both timed by a host clock sampled in i_clk.
// Ports: i_clk/i_rst core clock and async reset; i_fsclk/i_fsdi/o_fsdo/o_fscts
// host serial lines; i_tx_data/i_tx_valid/o_tx_ready byte-in handshake;
// o_rx_data/o_rx_dest/o_rx_valid/i_rx_ready FIFO head; o_overrun drop pulse.
module fast_serial_device #(
  parameter int unsigned RX_DEPTH   = 4,
  parameter bit          SOURCE_BIT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_fsclk,
  input  logic       i_fsdi,
  output logic       o_fsdo,
  output logic       o_fscts,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_dest,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_overrun
);

  localparam int unsigned AW = $clog2(RX_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_DEST = 2'd2
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_WAIT  = 3'd1,
    TX_START = 3'd2,
    TX_DATA  = 3'd3,
    TX_SRC   = 3'd4,
    TX_STOP  = 3'd5
  } tx_state_e;

  // Both lines get the same depth so a sampled bit stays aligned with its
  // clock edge; the third fsclk flop only serves edge detection.
  logic fsclk_s1_q, fsclk_s2_q, fsclk_d1_q;
  logic fsdi_s1_q, fsdi_s2_q;
  logic fs_rise, fs_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fsclk_s1_q <= 1'b1;
      fsclk_s2_q <= 1'b1;
      fsclk_d1_q <= 1'b1;
      fsdi_s1_q  <= 1'b1;
      fsdi_s2_q  <= 1'b1;
    end else begin
      fsclk_s1_q <= i_fsclk;
      fsclk_s2_q <= fsclk_s1_q;
      fsclk_d1_q <= fsclk_s2_q;
      fsdi_s1_q  <= i_fsdi;
      fsdi_s2_q  <= fsdi_s1_q;
    end
  end

  assign fs_rise = fsclk_s2_q & ~fsclk_d1_q;
  assign fs_fall = ~fsclk_s2_q & fsclk_d1_q;

  // ---------------- RX ----------------
  rx_state_e   rx_state_q, rx_state_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_dest_q, rx_dest_d;
  logic        rx_push_q, rx_push_d;
  logic        cts_q, cts_d;

  logic [8:0]    mem_q [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;
  logic [8:0]    head;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_dest_q  <= 1'b0;
      rx_push_q  <= 1'b0;
      cts_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_dest_q  <= rx_dest_d;
      rx_push_q  <= rx_push_d;
      cts_q      <= cts_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_dest_d  = rx_dest_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (fs_rise && !fsdi_s2_q) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = '0;
        end
      end
      RX_DATA: begin
        if (fs_rise) begin
          rx_shift_d = {fsdi_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = rx_cnt_q + 3'd1;
          if (rx_cnt_q == 3'd7) rx_state_d = RX_DEST;
        end
      end
      RX_DEST: begin
        if (fs_rise) begin
          rx_dest_d  = fsdi_s2_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // CTS is frozen for the whole frame so the host sees a stable level.
  always_comb begin
    rx_push_d = (rx_state_q == RX_DEST) && fs_rise;
    cts_d     = cts_q;
    if (rx_state_q == RX_IDLE) cts_d = (count_q < FULL_CNT);
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = rx_push_q & ~full;
  assign pop   = ~empty & i_rx_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {rx_dest_q, rx_shift_q};
  end

  // Storage is not reset; the empty gate keeps the head at zero instead.
  assign head       = mem_q[rd_ptr_q];
  assign o_rx_valid = ~empty;
  assign o_rx_data  = empty ? 8'h00 : head[7:0];
  assign o_rx_dest  = ~empty & head[8];
  assign o_overrun  = rx_push_q & full;
  assign o_fscts    = cts_q;

  // ---------------- TX ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [2:0] tx_cnt_q, tx_cnt_d;
  logic       tx_fsdo_q, tx_fsdo_d;
  logic       tx_live_q;
  logic       tx_accept;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q <= TX_IDLE;
      tx_byte_q  <= '0;
      tx_cnt_q   <= '0;
      tx_fsdo_q  <= 1'b1;
      tx_live_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_byte_q  <= tx_byte_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_fsdo_q  <= tx_fsdo_d;
      tx_live_q  <= 1'b1;
    end
  end

  assign tx_accept = i_tx_valid & o_tx_ready;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_byte_d  = tx_byte_q;
    tx_cnt_d   = tx_cnt_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_accept) begin
          tx_byte_d  = i_tx_data;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT:  if (fs_fall) tx_state_d = TX_START;
      TX_START: begin
        if (fs_fall) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
        end
      end
      TX_DATA: begin
        if (fs_fall) begin
          if (tx_cnt_q == 3'd7) tx_state_d = TX_SRC;
          else tx_cnt_d = tx_cnt_q + 3'd1;
        end
      end
      TX_SRC:  if (fs_fall) tx_state_d = TX_STOP;
      TX_STOP: if (fs_fall) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // tx_cnt_q names the bit on the line; a fall advances to the next one.
  always_comb begin
    o_tx_ready = (tx_state_q == TX_IDLE) & tx_live_q;
    tx_fsdo_d  = tx_fsdo_q;
    if (fs_fall) begin
      unique case (tx_state_q)
        TX_WAIT:  tx_fsdo_d = 1'b0;
        TX_START: tx_fsdo_d = tx_byte_q[0];
        TX_DATA:  tx_fsdo_d = (tx_cnt_q == 3'd7) ? SOURCE_BIT
                                                  : tx_byte_q[tx_cnt_q + 3'd1];
        TX_SRC:   tx_fsdo_d = 1'b1;
        default:  tx_fsdo_d = tx_fsdo_q;
      endcase
    end
  end

  assign o_fsdo = tx_fsdo_q;

endmodule

// File: doc/fast_serial_device.md
FAST_SERIAL_DEVICE -- requirements
Module: fast_serial_device

Interface
REQ-001 SHALL have parameter RX_DEPTH, 4, RX FIFO depth in entries (power of 2, 2..16).
REQ-002 SHALL have parameter SOURCE_BIT, 0, value sent in the source-bit slot of every FSDO frame.
REQ-003 SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_fsclk  input  1  fast-serial clock from the host; asynchronous to i_clk.
REQ-006 SHALL have port i_fsdi  input  1  serial data from the host (host FSDI).
REQ-007 SHALL have port o_fsdo  output  1  serial data to the host (host FSDO).
REQ-008 SHALL have port o_fscts  output  1  clear-to-send to the host (host FSCTS).
REQ-009 SHALL have port i_tx_data  input  8  byte to send to the host.
REQ-010 SHALL have port i_tx_valid  input  1  i_tx_data valid.
REQ-011 SHALL have port o_tx_ready  output  1  byte accepted on the cycle where i_tx_valid and o_tx_ready are both high.
REQ-012 SHALL have port o_rx_data  output  8  head-of-FIFO received byte.
REQ-013 SHALL have port o_rx_dest  output  1  destination bit stored with o_rx_data.
REQ-014 SHALL have port o_rx_valid  output  1  FIFO not empty.
REQ-015 SHALL have port i_rx_ready  input  1  pop the FIFO when high with o_rx_valid.
REQ-016 SHALL have port o_overrun  output  1  one-cycle pulse when a frame is dropped.

Function
REQ-017 SHALL pass i_fsclk and i_fsdi through two-flop synchronizers of equal depth; rising and falling FSCLK edges SHALL be detected from the synchronized FSCLK only.
REQ-018 Frame format on both lines SHALL be: start bit 0, 8 data bits LSB first, one channel bit; idle line level 1.
REQ-019 RX FSM SHALL use states IDLE, DATA, DEST: IDLE->DATA on an FSCLK rising edge sampling fsdi=0; DATA shifts in 8 bits, one per rising edge; DEST samples the channel bit and returns to IDLE.
REQ-020 In DEST, {dest, byte} SHALL be written into the FIFO on the cycle after sampling if the FIFO is not full; otherwise the frame SHALL be dropped and o_overrun pulsed for one cycle.
REQ-021 The FIFO SHALL be first-word-fall-through; a simultaneous push and pop SHALL both occur, with the count unchanged.
REQ-022 o_fscts SHALL be a registered (FIFO count < RX_DEPTH) and SHALL update only while the RX FSM is in IDLE; it SHALL hold its value during a frame.
REQ-023 TX FSM SHALL use states IDLE, WAIT, START, DATA, SRC, STOP.
REQ-024 o_tx_ready SHALL be high only in TX IDLE; on accept, the byte SHALL be latched and the FSM SHALL enter WAIT.
REQ-025 TX SHALL change o_fsdo only on detected FSCLK falling edges, in this order: WAIT->START drives 0; START->DATA drives bits 0..7 on successive falls; DATA->SRC drives SOURCE_BIT; SRC->STOP drives 1; STOP->IDLE on the next fall.
REQ-026 The minimum gap from the end of the channel bit to the next start bit SHALL be one full FSCLK period of idle 1.
REQ-027 TX and RX SHALL operate fully independently and concurrently.
REQ-028 Correct operation SHALL require an FSCLK high and low time of at least 4 i_clk periods each; behaviour outside this range is undefined.
REQ-029 A start bit of 0 seen on a rising edge while CTS is low SHALL still be received (the host violated CTS), and the frame is subject to REQ-020.

Reset
REQ-030 While i_rst is high: o_fsdo=1, o_fscts=0, o_tx_ready=0, o_rx_valid=0, o_overrun=0, o_rx_data=0, o_rx_dest=0; FIFO empty; both FSMs in IDLE; synchronizers set to 1.
REQ-031 Reset asserted mid-frame SHALL abort both frames at once, with o_fsdo returning to 1 asynchronously; no partial byte SHALL enter the FIFO.
REQ-032 After release, o_fscts SHALL rise on the first i_clk edge on which RX is IDLE, and o_tx_ready SHALL rise on the first i_clk edge.

Verification
REQ-033 Host sends 0xA5 with dest=1 (bits 0,1,0,1,0,0,1,0,1,1) -> o_rx_valid rises with o_rx_data=0xA5 and o_rx_dest=1, 3 to 4 i_clk cycles after the 10th FSCLK rise.
REQ-034 Send i_tx_data=0x3C with SOURCE_BIT=0 -> o_fsdo sequence on successive FSCLK falls is 0,0,0,1,1,1,1,0,0,0,1, then idle 1.
REQ-035 With i_rx_ready=0, host sends 4 frames -> o_fscts=0 after the 4th frame; a 5th frame sent anyway gives o_overrun for 1 cycle, the FIFO keeps the first 4 bytes in order, and o_fscts returns to 1 after one pop.
REQ-036 Simultaneous full-duplex: TX 0xFF while RX 0x00 -> both bytes correct, neither FSM stalls the other.
REQ-037 i_rst pulsed at RX data bit 4 and TX data bit 4 -> o_fsdo=1 immediately, FIFO empty, and the next complete frame is received and sent correctly.
REQ-038 Simultaneous pop and push with FIFO count 2 -> count stays 2, and the head advances in order.
